// File: rtl/tile_mem_arbiter.sv
// tile_mem_arbiter: merges N_PORTS OBI-style requestors onto a single TCDM-style memory port.
// Granted requests are tagged in an ID FIFO so that in-order memory responses are steered back
// to the port that issued them.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_req_i / in_gnt_o     per-port request / grant handshake
//   in_addr_i, in_we_i,
//   in_be_i, in_wdata_i     per-port request payload, packed port 0 in the LSBs
//   in_rvalid_o             per-port response valid
//   in_rdata_o, in_err_o    shared response data / error, qualified by in_rvalid_o
//   mem_*                   memory-side request, grant and response
//   outstanding_o           number of granted but unanswered transactions
//   spurious_o              sticky: a response arrived with nothing outstanding
module tile_mem_arbiter #(
  parameter int unsigned N_PORTS         = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned PRIO_MODE       = 0,
  localparam int unsigned BE_W           = DATA_W / 8,
  localparam int unsigned ID_W           = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_PORTS-1:0]          in_req_i,
  output logic [N_PORTS-1:0]          in_gnt_o,
  input  logic [N_PORTS*ADDR_W-1:0]   in_addr_i,
  input  logic [N_PORTS-1:0]          in_we_i,
  input  logic [N_PORTS*BE_W-1:0]     in_be_i,
  input  logic [N_PORTS*DATA_W-1:0]   in_wdata_i,
  output logic [N_PORTS-1:0]          in_rvalid_o,
  output logic [DATA_W-1:0]           in_rdata_o,
  output logic                        in_err_o,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic                        mem_we_o,
  output logic [BE_W-1:0]             mem_be_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic                        mem_rvalid_i,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  input  logic                        mem_err_i,
  output logic [CNT_W-1:0]            outstanding_o,
  output logic                        spurious_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]  fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  rr_q, rr_d, lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d, spurious_q, spurious_d;

  logic [ID_W-1:0]  arb_sel, sel, head;
  logic             full, mem_req, hs, pop;

  // Pointer increment with wrap for depths that are not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Arbitration: round-robin scans upward from rr_q with wrap, fixed priority from index 0.
  always_comb begin
    int unsigned idx;
    logic        found;
    arb_sel = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = (PRIO_MODE == 0) ? (32'(rr_q) + i) % N_PORTS : i;
      if (!found && in_req_i[idx]) begin
        arb_sel = ID_W'(idx);
        found   = 1'b1;
      end
    end
  end

  // A stalled request stays pinned to its port until the memory accepts it.
  assign sel     = lock_q ? lock_idx_q : arb_sel;
  assign head    = fifo_q[rd_ptr_q];
  assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  // Full depends only on registered count, so rvalid never opens a grant in the same cycle.
  assign mem_req = !rst_i && !full && (lock_q || (|in_req_i));
  assign hs      = mem_req && mem_gnt_i;
  assign pop     = !rst_i && mem_rvalid_i && (cnt_q != '0);

  always_comb begin
    in_gnt_o    = '0;
    in_rvalid_o = '0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (!rst_i && sel == ID_W'(p)) begin
        mem_addr_o  = in_addr_i[p*ADDR_W +: ADDR_W];
        mem_we_o    = in_we_i[p];
        mem_be_o    = in_be_i[p*BE_W +: BE_W];
        mem_wdata_o = in_wdata_i[p*DATA_W +: DATA_W];
        in_gnt_o[p] = hs;
      end
      if (pop && head == ID_W'(p)) in_rvalid_o[p] = 1'b1;
    end
  end

  assign mem_req_o     = mem_req;
  assign in_rdata_o    = pop ? mem_rdata_i : '0;
  assign in_err_o      = pop & mem_err_i;
  assign outstanding_o = rst_i ? '0 : cnt_q;
  assign spurious_o    = !rst_i && spurious_q;

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    spurious_d = spurious_q;

    if (hs) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      lock_d           = 1'b0;
      if (PRIO_MODE == 0) begin
        rr_d = (sel == ID_W'(N_PORTS - 1)) ? '0 : sel + ID_W'(1);
      end
    end else if (mem_req) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end

    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (mem_rvalid_i && cnt_q == '0) spurious_d = 1'b1;

    unique case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      spurious_q <= spurious_d;
    end
  end

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Directed bench: instance a is 3-port round-robin, instance b is 2-port fixed priority.
module tb_tile_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance a: N_PORTS=3, round-robin, MAX_OUTSTANDING=4
  logic [2:0]  a_req, a_gnt, a_we, a_rvalid;
  logic [95:0] a_addr, a_wdata;
  logic [11:0] a_be;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_err, a_mem_req, a_mem_gnt, a_mem_we, a_mem_rvalid, a_mem_err, a_spur;
  logic [3:0]  a_mem_be;
  logic [2:0]  a_out;

  // Instance b: N_PORTS=2, fixed priority
  logic [1:0]  b_req, b_gnt, b_we, b_rvalid;
  logic [63:0] b_addr, b_wdata;
  logic [7:0]  b_be;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_err, b_mem_req, b_mem_gnt, b_mem_we, b_mem_rvalid, b_mem_err, b_spur;
  logic [3:0]  b_mem_be;
  logic [2:0]  b_out;

  tile_mem_arbiter #(
    .N_PORTS(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .PRIO_MODE(0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_req_i(a_req), .in_gnt_o(a_gnt), .in_addr_i(a_addr), .in_we_i(a_we), .in_be_i(a_be),
    .in_wdata_i(a_wdata), .in_rvalid_o(a_rvalid), .in_rdata_o(a_rdata), .in_err_o(a_err),
    .mem_req_o(a_mem_req), .mem_gnt_i(a_mem_gnt), .mem_addr_o(a_mem_addr), .mem_we_o(a_mem_we),
    .mem_be_o(a_mem_be), .mem_wdata_o(a_mem_wdata), .mem_rvalid_i(a_mem_rvalid),
    .mem_rdata_i(a_mem_rdata), .mem_err_i(a_mem_err), .outstanding_o(a_out), .spurious_o(a_spur)
  );

  tile_mem_arbiter #(
    .N_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .PRIO_MODE(1)
  ) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .in_req_i(b_req), .in_gnt_o(b_gnt), .in_addr_i(b_addr), .in_we_i(b_we), .in_be_i(b_be),
    .in_wdata_i(b_wdata), .in_rvalid_o(b_rvalid), .in_rdata_o(b_rdata), .in_err_o(b_err),
    .mem_req_o(b_mem_req), .mem_gnt_i(b_mem_gnt), .mem_addr_o(b_mem_addr), .mem_we_o(b_mem_we),
    .mem_be_o(b_mem_be), .mem_wdata_o(b_mem_wdata), .mem_rvalid_i(b_mem_rvalid),
    .mem_rdata_i(b_mem_rdata), .mem_err_i(b_mem_err), .outstanding_o(b_out), .spurious_o(b_spur)
  );

  task automatic clear_inputs();
    a_req = '0; a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = '0; a_mem_err = 1'b0;
    b_req = '0; b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = '0; b_mem_err = 1'b0;
    a_we = 3'b010; b_we = 2'b00;
    for (int p = 0; p < 3; p++) begin
      a_addr[p*32 +: 32]  = 32'h2000 + 32'(p * 4);
      a_wdata[p*32 +: 32] = 32'hA0 + 32'(p);
      a_be[p*4 +: 4]      = 4'(p + 1);
    end
    for (int p = 0; p < 2; p++) begin
      b_addr[p*32 +: 32]  = 32'h3000 + 32'(p * 4);
      b_wdata[p*32 +: 32] = 32'hB0 + 32'(p);
      b_be[p*4 +: 4]      = 4'hF;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1; a_req = 3'b111; a_mem_gnt = 1'b1;
    #1;
    checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", a_mem_req); end
    checks++; if (a_gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b want 000", a_gnt); end
    checks++; if (a_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", a_mem_addr); end
    @(negedge clk);
    rst = 1'b0; a_req = '0; a_mem_gnt = 1'b0;
    #1;
    checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL rst_out: got %0d want 0", a_out); end
    checks++; if (a_spur !== 1'b0) begin errors++; $display("FAIL rst_spur: got %b want 0", a_spur); end
    checks++; if (a_rvalid !== 3'b000 || a_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_resp: got rvalid=%b rdata=%h want 000/0", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    a_addr[31:0] = 32'h100; a_req = 3'b001; a_mem_gnt = 1'b1;
    #1;
    checks++; if (a_gnt !== 3'b001) begin errors++; $display("FAIL sr_gnt: got %b want 001", a_gnt); end
    checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h100) begin
      errors++; $display("FAIL sr_fwd: got req=%b addr=%h want 1/100", a_mem_req, a_mem_addr);
    end
    @(negedge clk);
    a_req = '0; a_mem_gnt = 1'b0; a_mem_rvalid = 1'b1; a_mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (a_out !== 3'd1) begin errors++; $display("FAIL sr_out1: got %0d want 1", a_out); end
    checks++; if (a_rvalid !== 3'b001) begin errors++; $display("FAIL sr_rvalid: got %b want 001", a_rvalid); end
    checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata: got %h want deadbeef", a_rdata); end
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    #1;
    checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL sr_out0: got %0d want 0", a_out); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL sr_rdata_idle: got %h want 0", a_rdata); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g, exp_v;
    logic [31:0] exp_d;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_req = 3'b111; a_mem_gnt = 1'b1; a_mem_rvalid = (k >= 1);
      exp_g = 3'b001 << (k % 3);
      exp_v = (k >= 1) ? (3'b001 << ((k - 1) % 3)) : 3'b000;
      exp_d = 32'hA0 + 32'(k % 3);
      #1;
      checks++; if (a_gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, a_gnt, exp_g); end
      checks++; if (a_rvalid !== exp_v) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, a_rvalid, exp_v); end
      checks++; if (a_mem_wdata !== exp_d) begin errors++; $display("FAIL rr_wdata[%0d]: got %h want %h", k, a_mem_wdata, exp_d); end
    end
    @(negedge clk);
    a_req = '0; a_mem_gnt = 1'b0; a_mem_rvalid = 1'b1;
    #1;
    checks++; if (a_rvalid !== 3'b100) begin errors++; $display("FAIL rr_last_rvalid: got %b want 100", a_rvalid); end
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    #1;
    checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL rr_out: got %0d want 0", a_out); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_req = 2'b11; b_mem_gnt = 1'b1; b_mem_rvalid = (k >= 1);
      #1;
      checks++; if (b_gnt !== 2'b01) begin errors++; $display("FAIL fp_gnt[%0d]: got %b want 01", k, b_gnt); end
    end
    @(negedge clk);
    b_req = 2'b10; b_mem_rvalid = 1'b1;
    #1;
    checks++; if (b_gnt !== 2'b10) begin errors++; $display("FAIL fp_gnt_p1: got %b want 10", b_gnt); end
    checks++; if (b_rvalid !== 2'b01) begin errors++; $display("FAIL fp_rvalid_p0: got %b want 01", b_rvalid); end
    @(negedge clk);
    b_req = '0; b_mem_gnt = 1'b0; b_mem_rvalid = 1'b1;
    #1;
    checks++; if (b_rvalid !== 2'b10) begin errors++; $display("FAIL fp_rvalid_p1: got %b want 10", b_rvalid); end
    @(negedge clk);
    b_mem_rvalid = 1'b0;
    #1;
    checks++; if (b_out !== 3'd0) begin errors++; $display("FAIL fp_out: got %0d want 0", b_out); end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_req = 3'b001; a_mem_gnt = 1'b1;
      #1;
      checks++; if (a_gnt !== 3'b001) begin errors++; $display("FAIL lim_gnt[%0d]: got %b want 001", k, a_gnt); end
    end
    @(negedge clk);
    #1;
    checks++; if (a_mem_req !== 1'b0 || a_gnt !== 3'b000) begin
      errors++; $display("FAIL lim_full: got req=%b gnt=%b want 0/000", a_mem_req, a_gnt);
    end
    checks++; if (a_out !== 3'd4) begin errors++; $display("FAIL lim_out4: got %0d want 4", a_out); end
    @(negedge clk);
    a_mem_rvalid = 1'b1;
    #1;
    checks++; if (a_gnt !== 3'b000) begin errors++; $display("FAIL lim_rv_nogrant: got %b want 000", a_gnt); end
    checks++; if (a_rvalid !== 3'b001) begin errors++; $display("FAIL lim_rv: got %b want 001", a_rvalid); end
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    #1;
    checks++; if (a_gnt !== 3'b001) begin errors++; $display("FAIL lim_resume: got %b want 001", a_gnt); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_req = '0; a_mem_gnt = 1'b0; a_mem_rvalid = 1'b1;
      #1;
      checks++; if (a_rvalid !== 3'b001) begin errors++; $display("FAIL lim_drain[%0d]: got %b want 001", k, a_rvalid); end
    end
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    #1;
    checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL lim_out0: got %0d want 0", a_out); end
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_req = (k == 2) ? 3'b011 : 3'b010; a_mem_gnt = 1'b0;
      #1;
      checks++; if (a_mem_addr !== 32'h2004 || a_gnt !== 3'b000) begin
        errors++; $display("FAIL lock_hold[%0d]: got addr=%h gnt=%b want 2004/000", k, a_mem_addr, a_gnt);
      end
    end
    @(negedge clk);
    a_req = 3'b011; a_mem_gnt = 1'b1;
    #1;
    checks++; if (a_gnt !== 3'b010 || a_mem_addr !== 32'h2004) begin
      errors++; $display("FAIL lock_gnt: got gnt=%b addr=%h want 010/2004", a_gnt, a_mem_addr);
    end
    @(negedge clk);
    a_req = 3'b001;
    #1;
    checks++; if (a_gnt !== 3'b001) begin errors++; $display("FAIL lock_next: got %b want 001", a_gnt); end
    @(negedge clk);
    a_req = '0; a_mem_gnt = 1'b0; a_mem_rvalid = 1'b1;
    #1;
    checks++; if (a_rvalid !== 3'b010) begin errors++; $display("FAIL lock_rv1: got %b want 010", a_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (a_rvalid !== 3'b001) begin errors++; $display("FAIL lock_rv0: got %b want 001", a_rvalid); end
    @(negedge clk);
    a_mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_req = 3'b001; a_mem_gnt = 1'b1;
    end
    @(negedge clk);
    a_req = '0; a_mem_gnt = 1'b0;
    #1;
    checks++; if (a_out !== 3'd2) begin errors++; $display("FAIL mid_out2: got %0d want 2", a_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_mem_rvalid = 1'b1; a_mem_rdata = 32'h55AA55AA;
      #1;
      checks++; if (a_rvalid !== 3'b000 || a_rdata !== 32'h0) begin
        errors++; $display("FAIL mid_rv[%0d]: got rvalid=%b rdata=%h want 000/0", k, a_rvalid, a_rdata);
      end
    end
    @(negedge clk);
    a_mem_rvalid = 1'b0;
    #1;
    checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL mid_out0: got %0d want 0", a_out); end
    checks++; if (a_spur !== 1'b1) begin errors++; $display("FAIL mid_spur: got %b want 1", a_spur); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_outstanding_limit();
    test_lock();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
- Parametrised N-to-1 arbiter that merges several OBI-style requestors onto one HCI/TCDM-style memory port inside the RedMulE tile. Typical requestors are core data, DMA and external ports, which share a single log-interconnect slave.
- Tracks in-flight transactions in an ID FIFO so that in-order memory responses are routed back to the originating port.
- Supports round-robin or fixed-priority arbitration and a configurable outstanding-transaction limit.

Parameters:
- N_PORTS, 2, number of requestor ports (>=1).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions (>=1); sets ID FIFO depth.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- Derived: ID_W = max(1, $clog2(N_PORTS)); CNT_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- in_req_i  in  N_PORTS  per-port request.
- in_gnt_o  out  N_PORTS  per-port grant.
- in_addr_i  in  N_PORTS*ADDR_W  per-port address.
- in_we_i  in  N_PORTS  per-port write enable.
- in_be_i  in  N_PORTS*BE_W  per-port byte enables.
- in_wdata_i  in  N_PORTS*DATA_W  per-port write data.
- in_rvalid_o  out  N_PORTS  per-port response valid.
- in_rdata_o  out  DATA_W  response data, shared and qualified by in_rvalid_o.
- in_err_o  out  1  response error, qualified by in_rvalid_o.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  ADDR_W  memory address.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  BE_W  memory byte enables.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rvalid_i  in  1  memory response valid (responses return in order).
- mem_rdata_i  in  DATA_W  memory read data.
- mem_err_i  in  1  memory response error.
- outstanding_o  out  CNT_W  current in-flight transaction count.
- spurious_o  out  1  sticky flag: a response arrived with no transaction outstanding.

Behaviour:
- Reset (synchronous, rst_i=1 at the clock edge):
  - ID FIFO flushed, count = 0, RR pointer = 0, lock cleared, spurious_o = 0.
  - All outputs low or zero during and after reset.
- Full: count == MAX_OUTSTANDING. While full, mem_req_o = 0 and all in_gnt_o = 0, even if mem_rvalid_i = 1 in the same cycle. There is no combinational path from rvalid to gnt.
- Selection when not locked:
  - PRIO_MODE = 0: first requesting port at or after the RR pointer, searching upward with wrap-around.
  - PRIO_MODE = 1: lowest-index requesting port.
- Forwarding:
  - mem_req_o = !full & (locked | any in_req_i).
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are taken combinationally from the selected port.
- Lock: if mem_req_o = 1 and mem_gnt_i = 0, register the selected index and set lock. The selection holds on that port until a handshake, regardless of new higher-priority requests. Requestors hold req until gnt, per OBI.
- Handshake (mem_req_o & mem_gnt_i):
  - in_gnt_o[sel] = 1 combinationally, all other grants 0.
  - Push sel into the ID FIFO and clear lock.
  - RR pointer <= (sel+1) mod N_PORTS; the pointer is updated only in mode 0.
- Response: on mem_rvalid_i with count > 0:
  - Pop the FIFO head h.
  - in_rvalid_o[h] = 1 combinationally (zero added latency).
  - in_rdata_o = mem_rdata_i and in_err_o = mem_err_i.
- Spurious response: mem_rvalid_i with count == 0 → no in_rvalid_o, FIFO unchanged, spurious_o <= 1 (sticky until reset).
- Count update:
  - +1 on handshake, -1 on valid pop; simultaneous push and pop leaves count unchanged.
  - Count never exceeds MAX_OUTSTANDING and never underflows.
- Otherwise in_rdata_o and in_err_o are 0 when no response is delivered.
- N_PORTS = 1: arbitration is degenerate, sel is always 0 and the FIFO still counts transactions.
- Reset mid-operation: in-flight entries are discarded. Later mem_rvalid_i pulses are treated as spurious.

Test Plan:
- Single read: port 0 requests addr 0x100, mem_gnt_i = 1 in the same cycle, mem_rvalid_i the next cycle with rdata 0xDEADBEEF → in_gnt_o = 01, then in_rvalid_o = 01, in_rdata_o = 0xDEADBEEF, outstanding_o goes 1 then 0.
- Round-robin: PRIO_MODE = 0, N_PORTS = 3, all ports request continuously, mem_gnt_i = 1 → grant order 0,1,2,0,1,2. Responses route back in the same order.
- Fixed priority: PRIO_MODE = 1, ports 0 and 1 both request for 4 cycles → port 0 granted all 4 cycles, port 1 granted once port 0 drops its request.
- Outstanding limit: MAX_OUTSTANDING = 4 with no responses → exactly 4 grants, then mem_req_o = 0 and outstanding_o = 4. One rvalid → grant resumes the next cycle. A cycle with rvalid while full gives no grant in that cycle.
- Lock: port 1 selected, mem_gnt_i = 0 for 3 cycles, port 0 raises req in cycle 2 → mem_addr_o stays at port 1's address and port 1 receives the eventual grant.
- Reset mid-operation: 2 transactions outstanding, assert rst_i for 1 cycle, then send 2 mem_rvalid_i pulses → outstanding_o = 0, no in_rvalid_o, spurious_o = 1.
